// File: rtl/pipe_types_pkg.sv
// pipe_types_pkg: shared types for the pipeline stage register.
//   pipe_state_t : occupancy state of a stage (empty / one held / two held)
//   OCC_W        : width of the occupancy output
//   occ_of()     : state -> held entry count
package pipe_types_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_t;

  localparam int OCC_W = 2;

  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_t s);
    case (s)
      PS_BUSY: occ_of = 2'd1;
      PS_FULL: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   CLK, nRST : clock, async active-low reset
//   inc       : count one event this cycle
//   clr       : synchronous clear, wins over inc
//   count     : current value, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                     count <= '0;
    else if (clr)                  count <= '0;
    else if (inc && (count != '1)) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid/ready
// handshake, optional 2-entry skid buffer, hazard stall/flush and
// saturating event counters.
//   CLK, nRST            : clock, async active-low reset
//   in_valid/in_ready    : upstream handshake, in_data payload
//   out_valid/out_ready  : downstream handshake, out_data payload
//                          (NOP_VAL whenever out_valid=0)
//   stall                : freeze all state, gate both handshakes
//   flush                : squash held entries (beats stall and fires)
//   cnt_clr              : synchronous clear of both counters
//   occupancy            : held entries 0..2
//   stall_cnt/flush_cnt  : saturating event counts
module pipe_stage_reg
  import pipe_types_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter bit               SKID    = 1'b1,
  parameter logic [WIDTH-1:0] NOP_VAL = '0,
  parameter int               CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pipe_state_t      state, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_valid, skid_valid;
  logic             in_fire, out_fire;

  // Valid bits are pure decodes of the state flop, so in_ready in skid
  // mode never sees out_ready.
  assign main_valid = (state != PS_EMPTY);
  assign skid_valid = (state == PS_FULL);

  generate
    if (SKID) begin : g_skid
      assign in_ready = ~skid_valid & ~stall;
    end else begin : g_noskid
      assign in_ready = (~main_valid | out_ready) & ~stall;
    end
  endgenerate

  assign out_valid = main_valid & ~stall;
  assign out_data  = out_valid ? main_q : NOP_VAL;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = occ_of(state);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= PS_EMPTY;
      main_q <= NOP_VAL;
      skid_q <= NOP_VAL;
    end else begin
      state  <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // Stall needs no explicit hold term: it forces in_fire=out_fire=0.
  always_comb begin
    state_d = state;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = PS_EMPTY;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = PS_BUSY;
          end
        end
        PS_BUSY: begin
          if (out_fire && in_fire) begin
            main_d = in_data;
          end else if (out_fire) begin
            state_d = PS_EMPTY;
          end else if (in_fire && SKID) begin
            skid_d  = in_data;
            state_d = PS_FULL;
          end
        end
        PS_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = PS_BUSY;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall),
    .clr   (cnt_clr),
    .count (stall_cnt)
  );

  // Only flushes that actually squash something are counted.
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (flush & main_valid),
    .clr   (cnt_clr),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances share one stimulus stream,
// dut0 with skid buffer (CNT_W=16), dut1 without skid (CNT_W=2).
// Each instance has its own scoreboard queue of accepted, unflushed
// payloads; a monitor pops it whenever that instance fires an output.
module tb_pipe_stage_reg;
  localparam int W = 16;
  localparam logic [W-1:0] NOP = 16'hDEAD;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic         in_valid = 1'b0, out_ready = 1'b0, stall = 1'b0, flush = 1'b0, cnt_clr = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         rdy0, vld0, rdy1, vld1;
  logic [W-1:0] dat0, dat1;
  logic [1:0]   occ0, occ1;
  logic [15:0]  sc0, fc0;
  logic [1:0]   sc1, fc1;

  pipe_stage_reg #(.WIDTH(W), .SKID(1'b1), .NOP_VAL(NOP), .CNT_W(16)) u_dut0 (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .out_valid(vld0), .out_ready(out_ready), .out_data(dat0), .stall(stall),
    .flush(flush), .cnt_clr(cnt_clr), .occupancy(occ0), .stall_cnt(sc0), .flush_cnt(fc0));

  pipe_stage_reg #(.WIDTH(W), .SKID(1'b0), .NOP_VAL(NOP), .CNT_W(2)) u_dut1 (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .out_valid(vld1), .out_ready(out_ready), .out_data(dat1), .stall(stall),
    .flush(flush), .cnt_clr(cnt_clr), .occupancy(occ1), .stall_cnt(sc1), .flush_cnt(fc1));

  int total = 0;
  int bad = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int scnt[2];
  int fcnt[2];
  int cmax[2];
  int n_s[2];
  logic er_s[2];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, d, $time, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [W-1:0] qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  // Expected outputs follow from how many entries the stage holds.
  task automatic check_dut(input int d, input logic rdy, input logic vld,
                           input logic [W-1:0] dat, input logic [1:0] occ,
                           input int sc, input int fc);
    int n;
    logic er, ev;
    n  = qsize(d);
    er = (d == 0) ? ((n < 2) && !stall) : ((n == 0 || out_ready) && !stall);
    ev = (n > 0) && !stall;
    n_s[d]  = n;
    er_s[d] = er;
    chk("in_ready", d, rdy, er);
    chk("out_valid", d, vld, ev);
    if (!ev) chk("out_data_nop", d, dat, NOP);
    chk("occupancy", d, occ, n);
    chk("stall_cnt", d, sc, scnt[d]);
    chk("flush_cnt", d, fc, fcnt[d]);
  endtask

  task automatic upd(input int d);
    if (cnt_clr) scnt[d] = 0;
    else if (stall && scnt[d] < cmax[d]) scnt[d]++;
    if (cnt_clr) fcnt[d] = 0;
    else if (flush && n_s[d] > 0 && fcnt[d] < cmax[d]) fcnt[d]++;
    if (flush) begin
      if (d == 0) q0.delete(); else q1.delete();
    end else if (in_valid && er_s[d]) begin
      if (d == 0) q0.push_back(in_data); else q1.push_back(in_data);
    end
  endtask

  task automatic cyc(input logic iv, input logic [W-1:0] id, input logic ordy,
                     input logic st, input logic fl, input logic clr);
    @(negedge CLK);
    in_valid = iv; in_data = id; out_ready = ordy; stall = st; flush = fl; cnt_clr = clr;
    #1;
    check_dut(0, rdy0, vld0, dat0, occ0, int'(sc0), int'(fc0));
    check_dut(1, rdy1, vld1, dat1, occ1, int'(sc1), int'(fc1));
    @(posedge CLK);
    upd(0);
    upd(1);
  endtask

  task automatic reset_checks();
    chk("rst_out_valid", 0, vld0, 1'b0);
    chk("rst_out_valid", 1, vld1, 1'b0);
    chk("rst_out_data", 0, dat0, NOP);
    chk("rst_out_data", 1, dat1, NOP);
    chk("rst_occupancy", 0, occ0, 2'd0);
    chk("rst_occupancy", 1, occ1, 2'd0);
    chk("rst_in_ready", 0, rdy0, !stall);
    chk("rst_in_ready", 1, rdy1, !stall);
    chk("rst_stall_cnt", 0, sc0, 16'd0);
    chk("rst_stall_cnt", 1, sc1, 2'd0);
    chk("rst_flush_cnt", 0, fc0, 16'd0);
    chk("rst_flush_cnt", 1, fc1, 2'd0);
  endtask

  task automatic clear_model();
    q0.delete(); q1.delete();
    scnt[0] = 0; scnt[1] = 0; fcnt[0] = 0; fcnt[1] = 0;
  endtask

  // Reset pulse placed between clock edges, checked before any edge.
  task automatic areset();
    @(negedge CLK);
    #3;
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    nRST = 1'b0;
    #1;
    reset_checks();
    clear_model();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // Monitor: consumes one expected payload per output fire.
  always begin
    @(negedge CLK);
    #2;
    if (nRST) begin
      if (vld0 && out_ready) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL out_underflow dut0 t=%0t: got %h expected none", $time, dat0);
        end else chk("out_data", 0, dat0, q0.pop_front());
      end
      if (vld1 && out_ready) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL out_underflow dut1 t=%0t: got %h expected none", $time, dat1);
        end else chk("out_data", 1, dat1, q1.pop_front());
      end
    end
  end

  initial begin
    cmax[0] = 65535;
    cmax[1] = 3;
    clear_model();
    stall = 1'b1;
    #1;
    reset_checks();
    stall = 1'b0;
    #1;
    reset_checks();
    @(negedge CLK);
    nRST = 1'b1;

    // streaming at full rate
    cyc(1, 16'h0011, 1, 0, 0, 0);
    cyc(1, 16'h0022, 1, 0, 0, 0);
    cyc(1, 16'h0033, 1, 0, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0, 0);
    // fill with downstream blocked, then drain
    cyc(1, 16'h00A1, 0, 0, 0, 0);
    cyc(1, 16'h00A2, 0, 0, 0, 0);
    cyc(1, 16'h00A3, 0, 0, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0, 0);
    // back-to-back replace with main held
    cyc(1, 16'h00B1, 0, 0, 0, 0);
    cyc(0, 16'h0000, 0, 0, 0, 0);
    cyc(1, 16'h00B2, 1, 0, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0, 0);
    // flush beats stall and in_fire; second flush on empty not counted
    cyc(1, 16'h00C1, 0, 0, 0, 0);
    cyc(1, 16'h00C2, 0, 0, 0, 0);
    cyc(1, 16'h00C3, 0, 1, 1, 0);
    cyc(0, 16'h0000, 0, 0, 1, 0);
    cyc(0, 16'h0000, 1, 0, 0, 0);
    // long stall holding one payload
    cyc(1, 16'h00D1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 16'h0000, 1, 1, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0, 0);
    // stall saturation, then clear colliding with a stall cycle
    for (int i = 0; i < 6; i++) cyc(0, 16'h0000, 1, 1, 0, 0);
    cyc(0, 16'h0000, 1, 1, 0, 1);
    cyc(0, 16'h0000, 1, 0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) areset();
      cyc(($urandom_range(3, 0) != 0), W'($urandom), $urandom_range(1, 0) == 1,
          ($urandom_range(4, 0) == 0), ($urandom_range(15, 0) == 0),
          ($urandom_range(31, 0) == 0));
    end
    cyc(0, 16'h0000, 1, 0, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0, 0);
    cyc(0, 16'h0000, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register that replaces the hand-written IF/ID, ID/EX, EX/MEM and MEM/WB latches in the pipelined datapath. It carries an opaque payload of WIDTH bits, normally a packed stage struct. It adds:
- a valid/ready handshake
- an optional 2-entry skid buffer, so in_ready is registered and does not depend on out_ready
- stall and flush control from the hazard unit
- saturating stall and flush event counters for the CPU tracker

Parameters:
WIDTH, 32, payload width in bits; set to the $bits() of the stage struct.
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
NOP_VAL, '0 (WIDTH bits), bubble payload driven on out_data when out_valid=0 and loaded into the data registers on reset and on flush.
CNT_W, 16, width of each event counter.

Ports:
CLK  in  1  clock; all state updates on the rising edge
nRST  in  1  asynchronous active-low reset
in_valid  in  1  upstream has a payload
in_ready  out  1  stage can accept a payload this cycle
in_data  in  WIDTH  upstream payload
out_valid  out  1  stage presents a payload
out_ready  in  1  downstream accepts this cycle
out_data  out  WIDTH  presented payload; NOP_VAL when out_valid=0
stall  in  1  hazard-unit freeze
flush  in  1  squash all held entries (branch/jump mispredict)
cnt_clr  in  1  synchronous clear of both counters
occupancy  out  2  held entries: 0, 1 or 2
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of effective flushes

Behaviour:
Clock and reset: one clock, CLK. Reset nRST is asynchronous and active-low.

Reset state (nRST=0, asynchronous):
- main_valid = 0, skid_valid = 0, state = PS_EMPTY
- main and skid data registers = NOP_VAL
- stall_cnt = 0, flush_cnt = 0
- Resulting outputs: out_valid = 0, out_data = NOP_VAL, occupancy = 0, in_ready = 1 (0 if stall=1)
- Reset asserted mid-transfer drops every held entry; there is no partial update.

Handshake definitions:
- in_fire = in_valid & in_ready
- out_fire = out_valid & out_ready
- Latency is 1 cycle: a payload accepted on edge N is visible on out_data after edge N.

Outputs:
- out_valid = main_valid & ~stall
- out_data = main data when out_valid = 1, else NOP_VAL
- in_ready when SKID=1: ~skid_valid & ~stall (skid_valid is a flop)
- in_ready when SKID=0: (~main_valid | out_ready) & ~stall

State machine (state register of type pipe_state_t; occupancy = 0 / 1 / 2 for the three states):
- PS_EMPTY:
  - in_fire: main <= in_data, go to PS_BUSY
  - otherwise: stay
- PS_BUSY, four cases:
  - out_fire & in_fire: main <= in_data, stay
  - out_fire only: go to PS_EMPTY
  - in_fire only (SKID=1): skid <= in_data, go to PS_FULL
  - neither: hold
- PS_BUSY with SKID=0: PS_FULL is unreachable, because in_ready=0 whenever main is valid and out_ready=0.
- PS_FULL:
  - in_ready = 0
  - out_fire: main <= skid, skid_valid <= 0, go to PS_BUSY
  - otherwise: hold
- Ordering: payloads leave in acceptance order; no reordering and no duplication.

Stall:
- Freezes all data and state registers; both handshakes are suppressed through the in_ready and out_valid gating.
- stall_cnt increments once per cycle while stall=1.

Flush:
- Highest priority over stall, in_fire and out_fire.
- Next edge: both valids = 0, both data registers = NOP_VAL, state = PS_EMPTY.
- A payload offered with in_fire in the flush cycle is discarded; upstream treats it as consumed.
- flush_cnt increments only if occupancy was nonzero in the flush cycle.

Counters:
- Saturate at all-ones.
- cnt_clr wins over an increment in the same cycle.
- cnt_clr does not affect the datapath.

Decomposition:
- New package pipe_types_pkg:
  - typedef enum logic [1:0] pipe_state_t {PS_EMPTY, PS_BUSY, PS_FULL}
  - localparam OCC_W = 2
- Stage payload structs (IF_ID_t, ID_EX_t, EX_MEM_t, MEM_WB_t) stay in dp_types_pkg. They are passed through as WIDTH = $bits(struct), with NOP_VAL = the zeroed struct.
- One sub-module: sat_counter (parameter CNT_W; inputs inc and clr; output count), instantiated twice.

Test Plan:
- Reset, then stream 0x11, 0x22, 0x33 with in_valid=1 and out_ready=1: out_data shows 0x11, 0x22, 0x33 on consecutive cycles, each 1 cycle after acceptance; occupancy = 1 throughout.
- SKID=1, out_ready=0, offer 0xA1 then 0xA2: both accepted, occupancy = 2, in_ready = 0. Then raise out_ready: 0xA1 then 0xA2 appear and occupancy returns to 0.
- SKID=0, out_ready=0 with main holding 0xB1: in_ready = 0. Set out_ready=1 while offering 0xB2: in_ready = 1 in that same cycle and 0xB2 follows 0xB1 back to back.
- PS_FULL (0xC1, 0xC2) with flush=1, stall=1 and in_valid=1 (0xC3) all asserted: next cycle out_valid = 0, out_data = NOP_VAL, occupancy = 0, flush_cnt = 1. A second flush while empty leaves flush_cnt = 1.
- Hold stall for 5 cycles with 0xD1 held: out_valid = 0, in_ready = 0, stall_cnt = 5. Release stall: 0xD1 is presented unchanged.
- CNT_W=2, hold stall for 6 cycles: stall_cnt saturates at 3. Pulse cnt_clr together with stall=1: stall_cnt = 0. Pulse nRST low between edges mid-stream: outputs reach their reset values immediately, asynchronously.
